elastic_pipeline_reg: RTL and testbench
=======================================

// Module: elastic_pipeline_reg
// PURPOSE
//  Parametrised successor to the plain enable register: a chain of DEPTH elastic
//  register stages carrying WIDTH-bit payload with valid/ready handshake, flush and
//  occupancy reporting. Sits between CPU pipeline stages (fetch->decode, decode->exec)
//  so that back-pressure stalls propagate without combinational ready paths.
// PARAMETERS
//  WIDTH  32  payload width in bits (>=1)
//  DEPTH  2   number of elastic stages (>=1); each stage holds up to 2 beats
// PORTS
//  clk        in   1                  rising-edge clock
//  reset      in   1                  asynchronous, active-high reset
//  flush      in   1                  synchronous discard of all held beats
//  in_valid   in   1                  upstream beat present
//  in_ready   out  1                  stage 0 can accept (registered, no comb path)
//  in_data    in   WIDTH              upstream payload
//  out_valid  out  1                  downstream beat present
//  out_ready  in   1                  downstream accepts
//  out_data   out  WIDTH              downstream payload
//  occupancy  out  $clog2(2*DEPTH+1)  number of beats currently held
// BEHAVIOUR
//  - Reset (async assert, sync release): all valid bits 0, all data regs 0,
//    in_ready=1, out_valid=0, out_data=0, occupancy=0.
//  - Transfer occurs on a clk edge where valid&&ready on the same side; data must
//    be held stable by the sender while valid&&!ready.
//  - Each stage: main (valid,data) + skid (valid,data). stage in_ready = !skid_valid.
//    stage out_valid = main_valid, out_data = main_data.
//  - Stage update per cycle, in priority order:
//      skid_valid && down_ready            -> main<=skid, skid_valid<=0
//      up_accept && (!main_valid||down_ready) -> main<=in
//      up_accept && main_valid && !down_ready -> skid<=in, skid_valid<=1
//      !up_accept && down_ready            -> main_valid<=0
//  - Latency: 1 cycle per stage, DEPTH cycles in->out with no back-pressure.
//  - Throughput: 1 beat/cycle sustained; beat order is strictly preserved.
//  - Skid absorbs exactly one beat after out_ready falls; in_ready deasserts the
//    cycle after stage 0 skid fills and reasserts the cycle after it drains.
//  - flush: next edge clears every valid bit (data regs unchanged); a beat accepted
//    on the flush cycle is dropped; out_valid=0 and occupancy=0 the following cycle.
//    flush with reset asserted: reset wins.
//  - occupancy = sum of all main_valid + skid_valid; max 2*DEPTH when full.
//  - Full chain: in_ready=0; out_ready=1 for one cycle frees one slot, in_ready
//    returns after the drain propagates to stage 0.
//  - Reset mid-transfer: all in-flight beats lost, no partial output.
// STRUCTURE
//  - Package pipeline_pkg: function occ_width(depth) = $clog2(2*depth+1);
//    typedef struct {logic valid; logic [W-1:0] data;} not required (keep flat).
//  - One sub-module: skid_stage #(WIDTH) holding main/skid regs; top generates
//    DEPTH instances, chains ready/valid, sums valid bits for occupancy.
// TESTING
//  1 Reset: assert reset mid-stream with 3 beats held -> out_valid=0, in_ready=1,
//    occupancy=0, out_data=0 immediately (async), holds after release.
//  2 Streaming DEPTH=2: in 0x11,0x22,0x33 back-to-back, out_ready=1 -> out 0x11 at
//    cycle 2, then 0x22,0x33 consecutive; occupancy never exceeds 2.
//  3 Back-pressure: out_ready=0, push beats until in_ready=0 -> exactly 4 accepted
//    (2*DEPTH), occupancy=4; release out_ready -> 4 beats in order, none lost/duped.
//  4 Flush: 3 beats held, flush=1 with in_valid=1 data 0xAA -> next cycle
//    occupancy=0, out_valid=0; 0xAA never appears at output.
//  5 Random valid/out_ready toggling, 1000 beats, WIDTH=8, DEPTH=1 and 4 ->
//    scoreboard order match; in_ready never depends combinationally on out_ready.
//  6 Single-beat latency DEPTH=3: one beat 0x5A, out_ready=1 -> out_valid
//    exactly 3 cycles after accept.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared helpers for the elastic pipeline register chain.
//   occ_width(depth) : bit width needed to count 0 .. 2*depth held beats.
package pipeline_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_DEPTH = 2;

    // Each stage holds at most two beats (main + skid).
    function automatic int occ_width(input int depth);
        return $clog2(2 * depth + 1);
    endfunction

endpackage

// File: rtl/skid_stage.sv
// One elastic register stage: a main register plus a one-beat skid buffer.
// The ready returned upstream is registered (!skid_valid_q), so no
// combinational path exists from down_ready to up_ready.
// Ports:
//   clk, reset          clock, async active-high reset
//   flush               synchronous clear of both valid bits
//   up_valid/up_ready/up_data        upstream handshake
//   down_valid/down_ready/down_data  downstream handshake (driven by main reg)
//   skid_held           skid buffer occupied (for occupancy counting)
module skid_stage
    import pipeline_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [WIDTH-1:0] up_data,
    output logic             down_valid,
    input  logic             down_ready,
    output logic [WIDTH-1:0] down_data,
    output logic             skid_held
);

    logic             main_valid_q, main_valid_d;
    logic [WIDTH-1:0] main_data_q,  main_data_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_data_q,  skid_data_d;
    logic             up_accept;

    assign up_ready   = !skid_valid_q;
    assign up_accept  = up_valid && !skid_valid_q;
    assign down_valid = main_valid_q;
    assign down_data  = main_data_q;
    assign skid_held  = skid_valid_q;

    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;

        if (skid_valid_q && down_ready) begin
            // Main beat leaves downstream; the skid beat moves up behind it.
            // up_accept is necessarily 0 here because up_ready = !skid_valid_q.
            main_valid_d = 1'b1;
            main_data_d  = skid_data_q;
            skid_valid_d = 1'b0;
        end else if (up_accept && (!main_valid_q || down_ready)) begin
            main_valid_d = 1'b1;
            main_data_d  = up_data;
        end else if (up_accept) begin
            // Main is stalled: park the beat that was already in flight.
            skid_valid_d = 1'b1;
            skid_data_d  = up_data;
        end else if (down_ready) begin
            main_valid_d = 1'b0;
        end

        // Flush drops valid bits only; payload registers keep their contents.
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

endmodule

// File: rtl/elastic_pipeline_reg.sv
// Chain of DEPTH elastic register stages with valid/ready handshake, flush
// and occupancy reporting. Every ready signal in the chain comes straight
// from a flop, so back-pressure never forms a combinational path.
// Ports:
//   clk, reset                       clock, async active-high reset
//   flush                            synchronous discard of all held beats
//   in_valid/in_ready/in_data        upstream side (stage 0)
//   out_valid/out_ready/out_data     downstream side (stage DEPTH-1)
//   occupancy                        number of beats currently held
module elastic_pipeline_reg
    import pipeline_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH-1:0]            in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIDTH-1:0]            out_data,
    output logic [occ_width(DEPTH)-1:0] occupancy
);

    localparam int OCC_W = occ_width(DEPTH);

    // Link i sits between stage i-1 and stage i; link 0 is the input port,
    // link DEPTH is the output port.
    logic [DEPTH:0]   link_valid;
    logic [DEPTH:0]   link_ready;
    logic [WIDTH-1:0] link_data [DEPTH+1];
    logic [DEPTH-1:0] skid_held;
    logic [OCC_W-1:0] occ_sum;

    assign link_valid[0]     = in_valid;
    assign link_data[0]      = in_data;
    assign in_ready          = link_ready[0];
    assign link_ready[DEPTH] = out_ready;
    assign out_valid         = link_valid[DEPTH];
    assign out_data          = link_data[DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        skid_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk        (clk),
            .reset      (reset),
            .flush      (flush),
            .up_valid   (link_valid[i]),
            .up_ready   (link_ready[i]),
            .up_data    (link_data[i]),
            .down_valid (link_valid[i+1]),
            .down_ready (link_ready[i+1]),
            .down_data  (link_data[i+1]),
            .skid_held  (skid_held[i])
        );
    end

    // A stage's down_valid is its main_valid, so links 1..DEPTH plus the
    // skid bits cover every held beat.
    always_comb begin
        occ_sum = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_sum = occ_sum + OCC_W'(link_valid[i+1]) + OCC_W'(skid_held[i]);
        end
    end

    assign occupancy = occ_sum;

endmodule

// File: tb/tb_elastic_pipeline_reg.sv
module tb_elastic_pipeline_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // DEPTH=2, WIDTH=32
    logic        flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_data, out_data;
    logic [2:0]  occupancy;

    // DEPTH=3, WIDTH=32 (latency)
    logic        l_in_valid, l_in_ready, l_out_valid, l_out_ready;
    logic [31:0] l_in_data, l_out_data;
    logic [2:0]  l_occ;

    // Random streams: index 0 -> DEPTH=1, index 1 -> DEPTH=4, WIDTH=8
    logic       r_in_valid [2];
    logic       r_in_ready [2];
    logic       r_out_valid [2];
    logic       r_out_ready [2];
    logic [7:0] r_in_data [2];
    logic [7:0] r_out_data [2];
    logic [1:0] r1_occ;
    logic [3:0] r4_occ;

    int n_checks = 0;
    int n_errors = 0;

    elastic_pipeline_reg #(.WIDTH(32), .DEPTH(2)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy));

    elastic_pipeline_reg #(.WIDTH(32), .DEPTH(3)) dut_d3 (
        .clk(clk), .reset(reset), .flush(1'b0),
        .in_valid(l_in_valid), .in_ready(l_in_ready), .in_data(l_in_data),
        .out_valid(l_out_valid), .out_ready(l_out_ready), .out_data(l_out_data),
        .occupancy(l_occ));

    elastic_pipeline_reg #(.WIDTH(8), .DEPTH(1)) dut_d1 (
        .clk(clk), .reset(reset), .flush(1'b0),
        .in_valid(r_in_valid[0]), .in_ready(r_in_ready[0]), .in_data(r_in_data[0]),
        .out_valid(r_out_valid[0]), .out_ready(r_out_ready[0]), .out_data(r_out_data[0]),
        .occupancy(r1_occ));

    elastic_pipeline_reg #(.WIDTH(8), .DEPTH(4)) dut_d4 (
        .clk(clk), .reset(reset), .flush(1'b0),
        .in_valid(r_in_valid[1]), .in_ready(r_in_ready[1]), .in_data(r_in_data[1]),
        .out_valid(r_out_valid[1]), .out_ready(r_out_ready[1]), .out_data(r_out_data[1]),
        .occupancy(r4_occ));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, k, n, max1, max4, comb_bad, cyc;
        logic seen;
        int sent [2];
        int recv [2];
        int bad [2];
        logic pend [2];
        logic ir [2];
        logic [7:0] q0 [$];
        logic [7:0] q1 [$];
        logic [7:0] exp_b;

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        l_in_valid = 1'b0; l_in_data = '0; l_out_ready = 1'b0;
        for (int j = 0; j < 2; j++) begin
            r_in_valid[j] = 1'b0; r_in_data[j] = '0; r_out_ready[j] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        step();

        // Reset state
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_occ",       32'(occupancy), 32'd0);
        check("rst_out_data",  out_data,       32'd0);

        // Streaming, DEPTH=2
        out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h11;
        step();
        check("st_e1_valid", 32'(out_valid), 32'd0);
        check("st_e1_occ",   32'(occupancy), 32'd1);
        in_data = 32'h22;
        step();
        check("st_e2_valid", 32'(out_valid), 32'd1);
        check("st_e2_data",  out_data,       32'h11);
        check("st_e2_occ",   32'(occupancy), 32'd2);
        in_data = 32'h33;
        step();
        check("st_e3_data",  out_data,       32'h22);
        check("st_e3_occ",   32'(occupancy), 32'd2);
        in_valid = 1'b0;
        step();
        check("st_e4_data",  out_data,       32'h33);
        check("st_e4_occ",   32'(occupancy), 32'd1);
        step();
        check("st_e5_valid", 32'(out_valid), 32'd0);
        check("st_e5_occ",   32'(occupancy), 32'd0);

        // Back-pressure: fill to 2*DEPTH
        out_ready = 1'b0; acc = 0;
        for (int c = 0; c < 8; c++) begin
            logic was;
            in_valid = 1'b1;
            in_data  = 32'h100 + 32'(acc);
            was = in_ready;
            step();
            if (was) acc++;
        end
        in_valid = 1'b0;
        check("bp_accepted", 32'(acc),       32'd4);
        check("bp_occ_full", 32'(occupancy), 32'd4);
        check("bp_in_ready", 32'(in_ready),  32'd0);
        check("bp_head",     out_data,       32'h100);
        // One-cycle release frees a slot; in_ready follows after drain reaches stage 0
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp_rel1_in_ready", 32'(in_ready),  32'd0);
        check("bp_rel1_occ",      32'(occupancy), 32'd3);
        step();
        check("bp_rel2_in_ready", 32'(in_ready),  32'd1);
        check("bp_rel2_occ",      32'(occupancy), 32'd3);
        out_ready = 1'b1; k = 1;
        for (int c = 0; c < 12; c++) begin
            if (out_valid) begin
                check("bp_drain_data", out_data, 32'h100 + 32'(k));
                k++;
            end
            step();
        end
        check("bp_drain_count", 32'(k),         32'd4);
        check("bp_drain_occ",   32'(occupancy), 32'd0);

        // Flush with a beat offered on the flush cycle
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 32'h200 + 32'(i);
            step();
        end
        check("fl_occ_before", 32'(occupancy), 32'd3);
        in_data = 32'hAA; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_occ_after",   32'(occupancy), 32'd0);
        check("fl_valid_after", 32'(out_valid), 32'd0);
        out_ready = 1'b1; seen = 1'b0;
        repeat (6) begin
            if (out_valid) seen = 1'b1;
            step();
        end
        check("fl_no_output", 32'(seen), 32'd0);

        // Reset mid-stream with 3 beats held
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 32'h300 + 32'(i);
            step();
        end
        in_valid = 1'b0;
        check("rm_occ_before", 32'(occupancy), 32'd3);
        check("rm_data_before", out_data, 32'h300);
        #3 reset = 1'b1;
        #1;
        check("rm_async_valid", 32'(out_valid), 32'd0);
        check("rm_async_ready", 32'(in_ready),  32'd1);
        check("rm_async_occ",   32'(occupancy), 32'd0);
        check("rm_async_data",  out_data,       32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        step();
        check("rm_hold_valid", 32'(out_valid), 32'd0);
        check("rm_hold_ready", 32'(in_ready),  32'd1);
        check("rm_hold_occ",   32'(occupancy), 32'd0);

        // Single-beat latency, DEPTH=3
        l_out_ready = 1'b1; l_in_valid = 1'b1; l_in_data = 32'h5A;
        check("lat_in_ready", 32'(l_in_ready), 32'd1);
        step();
        l_in_valid = 1'b0; n = 1;
        while (!l_out_valid && n < 10) begin
            step();
            n++;
        end
        check("lat_cycles", 32'(n),     32'd3);
        check("lat_data",   l_out_data, 32'h5A);

        // Random valid/ready on DEPTH=1 and DEPTH=4
        for (int j = 0; j < 2; j++) begin
            sent[j] = 0; recv[j] = 0; bad[j] = 0; pend[j] = 1'b0;
        end
        max1 = 0; max4 = 0; comb_bad = 0; cyc = 0;
        while ((recv[0] < 1000 || recv[1] < 1000) && cyc < 8000) begin
            for (int j = 0; j < 2; j++) begin
                if (!pend[j]) begin
                    r_in_valid[j] = (sent[j] < 1000) && ($urandom_range(0, 3) != 0);
                    r_in_data[j]  = 8'(sent[j] * 37 + j * 5 + 1);
                end
                r_out_ready[j] = ($urandom_range(0, 2) != 0);
            end
            #1;
            for (int j = 0; j < 2; j++) begin
                ir[j] = r_in_ready[j];
                r_out_ready[j] = !r_out_ready[j];
            end
            #1;
            for (int j = 0; j < 2; j++) begin
                if (r_in_ready[j] !== ir[j]) comb_bad++;
                r_out_ready[j] = !r_out_ready[j];
            end
            #1;
            for (int j = 0; j < 2; j++) begin
                if (r_in_valid[j] && r_in_ready[j]) begin
                    if (j == 0) q0.push_back(r_in_data[j]);
                    else        q1.push_back(r_in_data[j]);
                    sent[j]++;
                    pend[j] = 1'b0;
                end else begin
                    pend[j] = r_in_valid[j];
                end
                if (r_out_valid[j] && r_out_ready[j]) begin
                    if (j == 0 && q0.size() == 0) bad[j]++;
                    else if (j == 1 && q1.size() == 0) bad[j]++;
                    else begin
                        exp_b = (j == 0) ? q0.pop_front() : q1.pop_front();
                        if (exp_b !== r_out_data[j]) bad[j]++;
                    end
                    recv[j]++;
                end
            end
            if (int'(r1_occ) > max1) max1 = int'(r1_occ);
            if (int'(r4_occ) > max4) max4 = int'(r4_occ);
            step();
            cyc++;
        end
        check("rnd_d1_order_errs", 32'(bad[0]),  32'd0);
        check("rnd_d1_beats",      32'(recv[0]), 32'd1000);
        check("rnd_d4_order_errs", 32'(bad[1]),  32'd0);
        check("rnd_d4_beats",      32'(recv[1]), 32'd1000);
        check("rnd_d1_occ_max_ok", 32'(max1 <= 2), 32'd1);
        check("rnd_d4_occ_max_ok", 32'(max4 <= 8), 32'd1);
        check("rnd_in_ready_comb", 32'(comb_bad),  32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
